// File: rtl/uart_hex_packet_codec.sv
// Purpose : ASCII-hex host packet codec between a byte UART and the bus master.
//           Decodes inbound 'L' frames into command/address/data words and encodes
//           outbound 'S' response frames terminated by a line feed.
// Ports   : clk/rst (sync, active-low); i_rx_byte/i_rx_stb from the UART receiver;
//           o_tx_byte/o_tx_stb/i_tx_busy to the UART transmitter; o_rx_error on an aborted frame;
//           o_ih_ready/i_master_ready plus o_in_* for decoded words;
//           o_oh_ready/i_oh_en plus i_out_* for response words.
// Config  : define UART_HEX_CODEC_TIMEOUT_EN to abort a stalled inbound frame after
//           TIMEOUT_CYCLES cycles without a received byte.

`ifndef COMMAND_READ
`define COMMAND_READ 16'h0001
`endif
`ifndef COMMAND_WRITE
`define COMMAND_WRITE 16'h0002
`endif

module uart_hex_packet_codec #(
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 28,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_rx_byte,
  input  logic                   i_rx_stb,
  output logic [7:0]             o_tx_byte,
  output logic                   o_tx_stb,
  input  logic                   i_tx_busy,
  output logic                   o_rx_error,
  output logic                   o_ih_ready,
  input  logic                   i_master_ready,
  output logic [DATA_WIDTH-1:0]  o_in_command,
  output logic [DATA_WIDTH-1:0]  o_in_address,
  output logic [DATA_WIDTH-1:0]  o_in_data,
  output logic [COUNT_WIDTH-1:0] o_in_data_count,
  output logic                   o_oh_ready,
  input  logic                   i_oh_en,
  input  logic [DATA_WIDTH-1:0]  i_out_status,
  input  logic [DATA_WIDTH-1:0]  i_out_address,
  input  logic [DATA_WIDTH-1:0]  i_out_data,
  input  logic [COUNT_WIDTH-1:0] i_out_data_count
);

  localparam int N_D  = DATA_WIDTH / 4;
  localparam int N_C  = COUNT_WIDTH / 4;
  // Narrow builds compare only the bits of the command that exist.
  localparam int CMDW = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_LF = 8'h0A;

  // {legal, nibble}; accepts 0-9, A-F, a-f.
  function automatic logic [4:0] hex_dec(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)
      return {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      return {1'b1, 4'(b[3:0] + 4'd9)};
    else
      return 5'b0;
  endfunction

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // ---------------------------------------------------------------- input side
  typedef enum logic [2:0] {I_IDLE, I_COUNT, I_CMD, I_ADDR, I_DATA, I_WAIT} in_state_t;

  in_state_t              in_st;
  logic [7:0]             in_nib;
  logic [COUNT_WIDTH-1:0] words_rcvd;
  logic [4:0]             rx_dec;
  logic                   rx_legal;
  logic [3:0]             rx_nib;
  logic                   in_last;
  logic [COUNT_WIDTH-1:0] rx_max_m1;
  logic                   is_write;

  assign rx_dec   = hex_dec(i_rx_byte);
  assign rx_legal = rx_dec[4];
  assign rx_nib   = rx_dec[3:0];
  assign in_last  = (in_nib == ((in_st == I_COUNT) ? 8'(N_C - 1) : 8'(N_D - 1)));
  // max(count,1)-1: words still to come after the first, never underflows.
  assign rx_max_m1 = (o_in_data_count == '0) ? '0 : o_in_data_count - 1'b1;
  assign is_write  = (o_in_command[CMDW-1:0] == CMDW'(`COMMAND_WRITE));

`ifdef UART_HEX_CODEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || i_rx_stb || in_st == I_IDLE || in_st == I_WAIT || to_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_st           <= I_IDLE;
      in_nib          <= '0;
      words_rcvd      <= '0;
      o_in_command    <= '0;
      o_in_address    <= '0;
      o_in_data       <= '0;
      o_in_data_count <= '0;
      o_ih_ready      <= 1'b0;
      o_rx_error      <= 1'b0;
    end else begin
      o_ih_ready <= 1'b0;
      o_rx_error <= 1'b0;
      case (in_st)
        I_IDLE: begin
          if (i_rx_stb && i_rx_byte == CH_L) begin
            o_in_command    <= '0;
            o_in_address    <= '0;
            o_in_data       <= '0;
            o_in_data_count <= '0;
            in_nib          <= '0;
            words_rcvd      <= '0;
            in_st           <= I_COUNT;
          end
        end
        I_COUNT, I_CMD, I_ADDR, I_DATA: begin
          if (i_rx_stb) begin
            if (rx_legal) begin
              case (in_st)
                I_COUNT: o_in_data_count <= {o_in_data_count[COUNT_WIDTH-5:0], rx_nib};
                I_CMD:   o_in_command    <= {o_in_command[DATA_WIDTH-5:0], rx_nib};
                I_ADDR:  o_in_address    <= {o_in_address[DATA_WIDTH-5:0], rx_nib};
                default: o_in_data       <= {o_in_data[DATA_WIDTH-5:0], rx_nib};
              endcase
              if (in_last) begin
                in_nib <= '0;
                case (in_st)
                  I_COUNT: in_st <= I_CMD;
                  I_CMD:   in_st <= I_ADDR;
                  I_ADDR:  in_st <= I_DATA;
                  default: in_st <= I_WAIT;
                endcase
              end else begin
                in_nib <= in_nib + 1'b1;
              end
            end else begin
              o_rx_error <= 1'b1;
              if (i_rx_byte == CH_L) begin
                // Resync: a stray 'L' is treated as the start of a fresh frame.
                o_in_command    <= '0;
                o_in_address    <= '0;
                o_in_data       <= '0;
                o_in_data_count <= '0;
                in_nib          <= '0;
                words_rcvd      <= '0;
                in_st           <= I_COUNT;
              end else begin
                in_st <= I_IDLE;
              end
            end
          end else if (to_hit) begin
            o_rx_error <= 1'b1;
            in_st      <= I_IDLE;
          end
        end
        I_WAIT: begin
          if (i_master_ready) begin
            o_ih_ready <= 1'b1;
            if (is_write && words_rcvd < rx_max_m1) begin
              words_rcvd <= words_rcvd + 1'b1;
              in_st      <= I_DATA;
            end else begin
              in_st <= I_IDLE;
            end
          end
        end
        default: in_st <= I_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- output side
  typedef enum logic [2:0] {O_IDLE, O_S, O_COUNT, O_STATUS, O_ADDR, O_DATA, O_NEXT, O_EOL} out_state_t;

  out_state_t             out_st;
  logic [7:0]             out_nib;
  logic [COUNT_WIDTH-1:0] cnt_lat;     // kept intact for the word-count decision
  logic [COUNT_WIDTH-1:0] cnt_sh;      // shifted out MSB-first
  logic [DATA_WIDTH-1:0]  status_sh;
  logic [DATA_WIDTH-1:0]  addr_sh;
  logic [DATA_WIDTH-1:0]  data_sh;
  logic [COUNT_WIDTH-1:0] words_sent;
  logic [COUNT_WIDTH-1:0] tx_max_m1;
  logic                   tx_wait;
  logic                   can_tx;
  logic                   out_last;
  logic [3:0]             cur_nib;

  // Hold off until the UART has acknowledged the previous strobe by going busy.
  assign can_tx    = !i_tx_busy && !tx_wait;
  assign tx_max_m1 = (cnt_lat == '0) ? '0 : cnt_lat - 1'b1;
  assign out_last  = (out_nib == ((out_st == O_COUNT) ? 8'(N_C - 1) : 8'(N_D - 1)));

  always_comb begin
    cur_nib = 4'h0;
    case (out_st)
      O_COUNT:  cur_nib = cnt_sh[COUNT_WIDTH-1 -: 4];
      O_STATUS: cur_nib = status_sh[DATA_WIDTH-1 -: 4];
      O_ADDR:   cur_nib = addr_sh[DATA_WIDTH-1 -: 4];
      O_DATA:   cur_nib = data_sh[DATA_WIDTH-1 -: 4];
      default:  cur_nib = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_st     <= O_IDLE;
      out_nib    <= '0;
      cnt_lat    <= '0;
      cnt_sh     <= '0;
      status_sh  <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      words_sent <= '0;
      tx_wait    <= 1'b0;
      o_tx_stb   <= 1'b0;
      o_tx_byte  <= '0;
      o_oh_ready <= 1'b0;
    end else begin
      o_tx_stb <= 1'b0;
      if (i_tx_busy)
        tx_wait <= 1'b0;
      case (out_st)
        O_IDLE: begin
          if (i_oh_en && o_oh_ready) begin
            cnt_lat    <= i_out_data_count;
            cnt_sh     <= i_out_data_count;
            status_sh  <= i_out_status;
            addr_sh    <= i_out_address;
            data_sh    <= i_out_data;
            words_sent <= '0;
            o_oh_ready <= 1'b0;
            out_st     <= O_S;
          end else begin
            o_oh_ready <= 1'b1;
          end
        end
        O_S: begin
          if (can_tx) begin
            o_tx_stb  <= 1'b1;
            o_tx_byte <= CH_S;
            tx_wait   <= 1'b1;
            out_nib   <= '0;
            out_st    <= O_COUNT;
          end
        end
        O_COUNT, O_STATUS, O_ADDR, O_DATA: begin
          if (can_tx) begin
            o_tx_stb  <= 1'b1;
            o_tx_byte <= hex_enc(cur_nib);
            tx_wait   <= 1'b1;
            case (out_st)
              O_COUNT:  cnt_sh    <= {cnt_sh[COUNT_WIDTH-5:0], 4'h0};
              O_STATUS: status_sh <= {status_sh[DATA_WIDTH-5:0], 4'h0};
              O_ADDR:   addr_sh   <= {addr_sh[DATA_WIDTH-5:0], 4'h0};
              default:  data_sh   <= {data_sh[DATA_WIDTH-5:0], 4'h0};
            endcase
            if (out_last) begin
              out_nib <= '0;
              case (out_st)
                O_COUNT:  out_st <= O_STATUS;
                O_STATUS: out_st <= O_ADDR;
                O_ADDR:   out_st <= O_DATA;
                default:  out_st <= O_NEXT;
              endcase
            end else begin
              out_nib <= out_nib + 1'b1;
            end
          end
        end
        O_NEXT: begin
          if (words_sent < tx_max_m1) begin
            if (i_oh_en && o_oh_ready) begin
              data_sh    <= i_out_data;
              words_sent <= words_sent + 1'b1;
              o_oh_ready <= 1'b0;
              out_nib    <= '0;
              out_st     <= O_DATA;
            end else begin
              o_oh_ready <= 1'b1;
            end
          end else begin
            out_st <= O_EOL;
          end
        end
        O_EOL: begin
          if (can_tx) begin
            o_tx_stb   <= 1'b1;
            o_tx_byte  <= CH_LF;
            tx_wait    <= 1'b1;
            o_oh_ready <= 1'b1;
            out_st     <= O_IDLE;
          end
        end
        default: out_st <= O_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_packet_codec.sv
// Purpose : directed bench for uart_hex_packet_codec (DW=32, CW=28, TIMEOUT_CYCLES=100).
// Covers  : reset values, read/write/count-0 frames, illegal byte, 'L' resync,
//           response framing with tx pacing and a long busy stall, timeout, mid-frame reset.

`ifndef COMMAND_READ
`define COMMAND_READ 16'h0001
`endif
`ifndef COMMAND_WRITE
`define COMMAND_WRITE 16'h0002
`endif

module tb_uart_hex_packet_codec;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_rx_byte;
  logic        i_rx_stb;
  logic [7:0]  o_tx_byte;
  logic        o_tx_stb;
  logic        i_tx_busy;
  logic        o_rx_error;
  logic        o_ih_ready;
  logic        i_master_ready;
  logic [31:0] o_in_command;
  logic [31:0] o_in_address;
  logic [31:0] o_in_data;
  logic [27:0] o_in_data_count;
  logic        o_oh_ready;
  logic        i_oh_en;
  logic [31:0] i_out_status;
  logic [31:0] i_out_address;
  logic [31:0] i_out_data;
  logic [27:0] i_out_data_count;

  uart_hex_packet_codec #(.DATA_WIDTH(32), .COUNT_WIDTH(28), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .i_rx_byte(i_rx_byte), .i_rx_stb(i_rx_stb),
    .o_tx_byte(o_tx_byte), .o_tx_stb(o_tx_stb), .i_tx_busy(i_tx_busy),
    .o_rx_error(o_rx_error), .o_ih_ready(o_ih_ready), .i_master_ready(i_master_ready),
    .o_in_command(o_in_command), .o_in_address(o_in_address),
    .o_in_data(o_in_data), .o_in_data_count(o_in_data_count),
    .o_oh_ready(o_oh_ready), .i_oh_en(i_oh_en),
    .i_out_status(i_out_status), .i_out_address(i_out_address),
    .i_out_data(i_out_data), .i_out_data_count(i_out_data_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor state, sampled on the falling edge.
  int          ih_cnt  = 0;
  int          err_cnt = 0;
  logic [31:0] cap_cmd   [64];
  logic [31:0] cap_addr  [64];
  logic [31:0] cap_data  [64];
  logic [27:0] cap_count [64];

  always @(negedge clk) begin
    if (o_ih_ready) begin
      cap_cmd[ih_cnt]   = o_in_command;
      cap_addr[ih_cnt]  = o_in_address;
      cap_data[ih_cnt]  = o_in_data;
      cap_count[ih_cnt] = o_in_data_count;
      ih_cnt            = ih_cnt + 1;
    end
    if (o_rx_error)
      err_cnt = err_cnt + 1;
  end

  // UART transmitter model: goes busy for a few cycles after each strobe.
  logic [7:0] tx_q[$];
  int         busy_cnt   = 0;
  logic       force_busy = 1'b0;
  logic       busy_seen  = 1'b1;
  int         pace_viol  = 0;

  initial begin
    i_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (i_tx_busy)
        busy_seen = 1'b1;
      if (o_tx_stb) begin
        if (!busy_seen)
          pace_viol = pace_viol + 1;
        busy_seen = 1'b0;
        tx_q.push_back(o_tx_byte);
        busy_cnt = 4;
      end
      if (force_busy)
        i_tx_busy = 1'b1;
      else if (busy_cnt > 0) begin
        i_tx_busy = 1'b1;
        busy_cnt  = busy_cnt - 1;
      end else
        i_tx_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_byte = b;
    i_rx_stb  = 1'b1;
    @(negedge clk);
    i_rx_stb  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i]);
  endtask

  int          ih0, err0, q0;
  int          waited;
  string       exp_s;
  logic [7:0]  exp_b;

  initial begin
    rst = 1'b0; i_rx_byte = 8'h00; i_rx_stb = 1'b0; i_master_ready = 1'b1;
    i_oh_en = 1'b0; i_out_status = '0; i_out_address = '0; i_out_data = '0; i_out_data_count = '0;

    // ---- reset values
    cycles(3);
    chk("rst_oh_ready", o_oh_ready, 0);
    chk("rst_ih_ready", o_ih_ready, 0);
    chk("rst_rx_error", o_rx_error, 0);
    chk("rst_tx_stb",   o_tx_stb,   0);
    chk("rst_tx_byte",  o_tx_byte,  0);
    chk("rst_in_words", {o_in_command, o_in_address}, 64'h0);
    chk("rst_in_data",  {o_in_data, 4'h0, o_in_data_count}, 64'h0);
    @(negedge clk); rst = 1'b1;
    cycles(1);
    chk("oh_ready_after_rst", o_oh_ready, 1);

    // ---- read frame, master initially not ready
    ih0 = ih_cnt; err0 = err_cnt;
    i_master_ready = 1'b0;
    send_str("L0000001000000010100001000000000");
    cycles(10);
    chk("read_held_no_pulse", ih_cnt - ih0, 0);
    i_master_ready = 1'b1;
    cycles(5);
    chk("read_pulses", ih_cnt - ih0, 1);
    chk("read_cmd",    cap_cmd[ih0],   32'h0000_0001);
    chk("read_addr",   cap_addr[ih0],  32'h0100_0010);
    chk("read_count",  cap_count[ih0], 28'h000_0001);
    chk("read_data",   cap_data[ih0],  32'h0000_0000);
    chk("read_no_err", err_cnt - err0, 0);

    // ---- write frame, three words, mixed case
    ih0 = ih_cnt; err0 = err_cnt;
    send_str("L000000300000002000000A0DEADBEEF00000001abcdef12");
    cycles(5);
    chk("write_pulses", ih_cnt - ih0, 3);
    chk("write_addr",   cap_addr[ih0],    32'h0000_00A0);
    chk("write_count",  cap_count[ih0],   28'h000_0003);
    chk("write_d0",     cap_data[ih0],    32'hDEAD_BEEF);
    chk("write_d1",     cap_data[ih0+1],  32'h0000_0001);
    chk("write_d2",     cap_data[ih0+2],  32'hABCD_EF12);
    chk("write_cmd_held", o_in_command,   32'h0000_0002);
    // Back in IDLE: a stray hex digit is ignored.
    send_str("5");
    cycles(5);
    chk("write_idle_after", {ih_cnt - ih0, err_cnt - err0}, {32'd3, 32'd0});

    // ---- write with count 0 carries exactly one word
    ih0 = ih_cnt;
    send_str("L000000000000002000000ffcafef00d");
    send_str("0");
    cycles(5);
    chk("cnt0_pulses", ih_cnt - ih0, 1);
    chk("cnt0_addr",   cap_addr[ih0], 32'h0000_00FF);
    chk("cnt0_data",   cap_data[ih0], 32'hCAFE_F00D);

    // ---- illegal byte in the address field
    ih0 = ih_cnt; err0 = err_cnt;
    send_str("L00000010000000101G");
    send_str("0000000000000");
    cycles(5);
    chk("illegal_err",      err_cnt - err0, 1);
    chk("illegal_no_pulse", ih_cnt - ih0,   0);

    // ---- 'L' mid-data resyncs into a fresh frame
    ih0 = ih_cnt; err0 = err_cnt;
    send_str("L00000010000000100000020" );
    send_str("12L000000100000001000000300000ABCD");
    cycles(5);
    chk("resync_err",    err_cnt - err0, 1);
    chk("resync_pulses", ih_cnt - ih0,   1);
    chk("resync_addr",   cap_addr[ih0],  32'h0000_0030);
    chk("resync_data",   cap_data[ih0],  32'h0000_ABCD);

    // ---- response frame with a 500-cycle busy stall
    tx_q.delete();
    busy_seen = 1'b1;
    @(negedge clk);
    chk("oh_ready_idle", o_oh_ready, 1);
    i_out_data_count = 28'd2; i_out_status = 32'h1; i_out_address = 32'h100; i_out_data = 32'h1234_5678;
    i_oh_en = 1'b1;
    @(negedge clk);
    i_oh_en = 1'b0;
    #1;
    chk("oh_ready_drops", o_oh_ready, 0);
    cycles(20);
    force_busy = 1'b1;
    cycles(2);
    q0 = tx_q.size();
    cycles(500);
    chk("busy_stall_no_stb", tx_q.size() - q0, 0);
    force_busy = 1'b0;
    waited = 0;
    while (!o_oh_ready && waited < 3000) begin
      cycles(1);
      waited++;
    end
    chk("next_word_ready", o_oh_ready, 1);
    i_out_data = 32'h9ABC_DEF0;
    @(negedge clk); i_oh_en = 1'b1;
    @(negedge clk); i_oh_en = 1'b0;
    waited = 0;
    while (tx_q.size() < 41 && waited < 3000) begin
      cycles(1);
      waited++;
    end
    cycles(20);
    chk("tx_len", tx_q.size(), 41);
    exp_s = "S00000020000000100000100123456789ABCDEF0";
    for (int i = 0; i < 41; i++) begin
      exp_b = (i < 40) ? exp_s[i] : 8'h0A;
      chk($sformatf("tx_byte_%0d", i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_b);
    end
    chk("tx_pacing", pace_viol, 0);
    chk("oh_ready_after_frame", o_oh_ready, 1);

    // ---- stalled inbound frame
    err0 = err_cnt;
    send_str("L00");
    cycles(300);
`ifdef UART_HEX_CODEC_TIMEOUT_EN
    chk("timeout_err", err_cnt - err0, 1);
`else
    chk("no_timeout_err", err_cnt - err0, 0);
`endif

    // ---- reset mid-frame discards the partial frame silently
    ih0 = ih_cnt; err0 = err_cnt;
    send_str("0000100000");
    @(negedge clk); rst = 1'b0;
    cycles(3);
    chk("midrst_oh_ready", o_oh_ready, 0);
    chk("midrst_in_addr",  o_in_address, 32'h0);
    @(negedge clk); rst = 1'b1;
    cycles(2);
    chk("midrst_quiet", {ih_cnt - ih0, err_cnt - err0}, 64'h0);
    send_str("L000000100000001000000550000FFFF");
    cycles(5);
    chk("midrst_recover_pulse", ih_cnt - ih0, 1);
    chk("midrst_recover_addr",  cap_addr[ih0], 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
